// File: rtl/load_store_unit.sv
// Memory-access stage: turns ALU address + rt into a ready/req data-memory
// transaction with byte/halfword lane steering, load extension and core stall.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ALUresult,
  input  logic [31:0] i_write_data,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic        o_stall,
  output logic [31:0] o_read_data,
  output logic        o_done,
  output logic        o_misaligned,
  output logic        o_bus_error,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                err_q, mis_q;
  logic [DATA_W-1:0]   addr_q, wdata_q;
  logic [3:0]          be_q;
  logic [1:0]          size_q;
  logic                we_q, uns_q;
  logic                access, misaligned, launch, timeout_hit;

  function automatic logic [DATA_W-1:0] steer_wdata(input logic [1:0] sz,
                                                    input logic [DATA_W-1:0] rt);
    logic [DATA_W-1:0] r;
    case (sz)
      2'b00:   r = {4{rt[7:0]}};
      2'b01:   r = {2{rt[15:0]}};
      default: r = rt;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] steer_be(input logic [1:0] sz, input logic [1:0] lane);
    logic [3:0] r;
    case (sz)
      2'b00:   r = 4'b0001 << lane;
      2'b01:   r = lane[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] extend_load(input logic [1:0] sz, input logic uns,
                                                    input logic [1:0] lane,
                                                    input logic [DATA_W-1:0] rdata);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (sz)
      2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  assign access = i_MemRead | i_MemWrite;

  always_comb begin
    misaligned = 1'b0;
    case (i_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = i_ALUresult[0];
      default: misaligned = (i_ALUresult[1:0] != 2'b00);
    endcase
  end

  assign launch      = (state == IDLE) && access && !misaligned;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    o_stall   = 1'b0;
    o_mem_req = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = ACCESS;
          o_stall   = 1'b1;
        end
      end
      ACCESS: begin
        o_stall   = 1'b1;
        o_mem_req = 1'b1;
        if (i_mem_ready || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are visible only while the access is outstanding
  assign o_mem_we     = (state == ACCESS) && we_q;
  assign o_mem_addr   = (state == ACCESS) ? {addr_q[31:2], 2'b00} : '0;
  assign o_mem_wdata  = (state == ACCESS) ? wdata_q : '0;
  assign o_mem_be     = (state == ACCESS) ? be_q : 4'b0000;
  assign o_done       = (state == DONE) && !err_q;
  assign o_bus_error  = (state == DONE) && err_q;
  assign o_misaligned = mis_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
      o_read_data <= '0;
    end else begin
      state <= state_nxt;
      mis_q <= (state == IDLE) && access && misaligned;
      if (state == ACCESS && !i_mem_ready) cnt <= cnt + 1'b1;
      else                                 cnt <= '0;
      if (state == ACCESS) err_q <= !i_mem_ready && timeout_hit;
      if (state == ACCESS && i_mem_ready && !we_q)
        o_read_data <= extend_load(size_q, uns_q, addr_q[1:0], i_mem_rdata);
    end
  end

  always_ff @(posedge i_clk) begin
    if (launch) begin
      addr_q  <= i_ALUresult;
      size_q  <= i_size;
      uns_q   <= i_unsigned;
      we_q    <= i_MemWrite;
      wdata_q <= steer_wdata(i_size, i_write_data);
      be_q    <= i_MemWrite ? steer_be(i_size, i_ALUresult[1:0]) : 4'b1111;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit (TIMEOUT_CYCLES=4).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, wdata_in;
  logic        mrd, mwr, uns;
  logic [1:0]  sz;
  logic        stall, done, mis, berr, req, we;
  logic [31:0] rdata_out, maddr, mwdata;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] mrdata;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_ALUresult(alu), .i_write_data(wdata_in),
    .i_MemRead(mrd), .i_MemWrite(mwr), .i_size(sz), .i_unsigned(uns),
    .o_stall(stall), .o_read_data(rdata_out), .o_done(done),
    .o_misaligned(mis), .o_bus_error(berr), .o_mem_req(req), .o_mem_we(we),
    .o_mem_addr(maddr), .o_mem_wdata(mwdata), .o_mem_be(be),
    .i_mem_ready(ready), .i_mem_rdata(mrdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                       input logic wr, input logic [1:0] s, input logic u);
    alu = a; wdata_in = wd; mrd = rd; mwr = wr; sz = s; uns = u;
    #1;
  endtask

  task automatic clear_inputs;
    alu = '0; wdata_in = '0; mrd = 1'b0; mwr = 1'b0; sz = 2'b00; uns = 1'b0;
    ready = 1'b0; mrdata = '0;
  endtask

  // Zero-wait load; returns sampled in the DONE cycle, then back to IDLE
  task automatic zero_wait_load(input string name, input logic [31:0] a, input logic [1:0] s,
                                input logic u, input logic [31:0] rd,
                                input logic [31:0] exp);
    drive(a, 32'h0, 1'b1, 1'b0, s, u);
    ready = 1'b1; mrdata = rd;
    tick;
    tick;
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL %s_done: got %b want 1", name, done); end
    n_checks++;
    if (rdata_out !== exp) begin n_fail++; $display("FAIL %s_data: got %h want %h", name, rdata_out, exp); end
    clear_inputs;
    tick;
  endtask

  task automatic test_reset;
    clear_inputs;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({stall, req, done, mis, berr, we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {stall, req, done, mis, berr, we});
    end
    n_checks++;
    if ({rdata_out, maddr, mwdata, be} !== 100'b0) begin
      n_fail++; $display("FAIL reset_data: got rd=%h addr=%h wd=%h be=%b want zeros", rdata_out, maddr, mwdata, be);
    end
  endtask

  task automatic test_zero_wait_load;
    drive(32'h100, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    ready = 1'b1; mrdata = 32'hDEADBEEF;
    n_checks++;
    if ({stall, req} !== 2'b10) begin n_fail++; $display("FAIL zw_detect: got stall,req=%b want 10", {stall, req}); end
    tick;
    n_checks++;
    if ({stall, req, we, be, maddr} !== {3'b110, 4'b1111, 32'h100}) begin
      n_fail++; $display("FAIL zw_access: got stall=%b req=%b we=%b be=%b addr=%h want 1 1 0 1111 00000100", stall, req, we, be, maddr);
    end
    tick;
    n_checks++;
    if ({done, stall, req, berr} !== 4'b1000) begin
      n_fail++; $display("FAIL zw_done: got done,stall,req,berr=%b want 1000", {done, stall, req, berr});
    end
    n_checks++;
    if (rdata_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL zw_data: got %h want deadbeef", rdata_out); end
    clear_inputs;
    tick;
    n_checks++;
    if ({done, stall, req} !== 3'b000) begin n_fail++; $display("FAIL zw_idle: got %b want 000", {done, stall, req}); end
  endtask

  task automatic test_byte_half_loads;
    zero_wait_load("lb",   32'h103, 2'b00, 1'b0, 32'h80AABBCC, 32'hFFFFFF80);
    zero_wait_load("lbu",  32'h103, 2'b00, 1'b1, 32'h80AABBCC, 32'h00000080);
    zero_wait_load("lh",   32'h102, 2'b01, 1'b0, 32'h80AABBCC, 32'hFFFF80AA);
    zero_wait_load("lhu",  32'h100, 2'b01, 1'b1, 32'h80AABBCC, 32'h0000BBCC);
    zero_wait_load("lb1",  32'h101, 2'b00, 1'b0, 32'h80AABBCC, 32'hFFFFFFBB);
  endtask

  task automatic check_store(input string name, input logic [31:0] a, input logic [1:0] s,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd,
                             input logic [31:0] exp_addr);
    drive(a, 32'h12345678, 1'b0, 1'b1, s, 1'b0);
    ready = 1'b1; mrdata = 32'hA5A5A5A5;
    tick;
    n_checks++;
    if ({req, we, be, mwdata, maddr} !== {2'b11, exp_be, exp_wd, exp_addr}) begin
      n_fail++;
      $display("FAIL %s: got req=%b we=%b be=%b wd=%h addr=%h want 1 1 %b %h %h",
               name, req, we, be, mwdata, maddr, exp_be, exp_wd, exp_addr);
    end
    tick;
    n_checks++;
    if ({done, rdata_out} !== {1'b1, 32'hFFFFFFBB}) begin
      n_fail++; $display("FAIL %s_done: got done=%b rd=%h want 1 ffffffbb", name, done, rdata_out);
    end
    clear_inputs;
    tick;
  endtask

  task automatic test_stores;
    check_store("sb", 32'h201, 2'b00, 4'b0010, 32'h78787878, 32'h200);
    check_store("sh", 32'h202, 2'b01, 4'b1100, 32'h56785678, 32'h200);
    check_store("sw", 32'h204, 2'b10, 4'b1111, 32'h12345678, 32'h204);
  endtask

  task automatic test_wait_states;
    int req_cycles = 0;
    int dones = 0;
    drive(32'h308, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    ready = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin ready = 1'b1; mrdata = 32'hCAFEF00D; #1; end
      if (req) req_cycles++;
      n_checks++;
      if ({maddr, be, we, berr} !== {32'h308, 4'b1111, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL ws_stable%0d: got addr=%h be=%b we=%b berr=%b want 00000308 1111 0 0", i, maddr, be, we, berr);
      end
      tick;
    end
    n_checks++;
    if (req_cycles !== 4) begin n_fail++; $display("FAIL ws_req_cycles: got %0d want 4", req_cycles); end
    if (done) dones++;
    n_checks++;
    if ({berr, rdata_out} !== {1'b0, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL ws_data: got berr=%b rd=%h want 0 cafef00d", berr, rdata_out);
    end
    clear_inputs;
    tick;
    if (done) dones++;
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL ws_single_done: got %0d want 1", dones); end
  endtask

  task automatic test_misaligned;
    drive(32'h101, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    n_checks++;
    if ({stall, req} !== 2'b00) begin n_fail++; $display("FAIL mis_lw_detect: got stall,req=%b want 00", {stall, req}); end
    tick;
    clear_inputs;
    #1;
    n_checks++;
    if ({mis, req, stall, done} !== 4'b1000) begin
      n_fail++; $display("FAIL mis_lw_pulse: got mis,req,stall,done=%b want 1000", {mis, req, stall, done});
    end
    tick;
    n_checks++;
    if ({mis, req} !== 2'b00) begin n_fail++; $display("FAIL mis_lw_clear: got %b want 00", {mis, req}); end
    drive(32'h203, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0);
    tick;
    clear_inputs;
    #1;
    n_checks++;
    if ({mis, req} !== 2'b10) begin n_fail++; $display("FAIL mis_sh_pulse: got mis,req=%b want 10", {mis, req}); end
    tick;
  endtask

  task automatic test_timeout;
    int req_cycles = 0;
    drive(32'h400, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    ready = 1'b0; mrdata = 32'h99999999;
    tick;
    for (int i = 0; i < 10 && req; i++) begin
      req_cycles++;
      tick;
    end
    n_checks++;
    if (req_cycles !== 4) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
    n_checks++;
    if ({berr, done, stall, req} !== 4'b1000) begin
      n_fail++; $display("FAIL to_pulse: got berr,done,stall,req=%b want 1000", {berr, done, stall, req});
    end
    n_checks++;
    if (rdata_out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL to_data_kept: got %h want cafef00d", rdata_out); end
    clear_inputs;
    tick;
    n_checks++;
    if ({berr, stall, req} !== 3'b000) begin n_fail++; $display("FAIL to_idle: got %b want 000", {berr, stall, req}); end
  endtask

  task automatic test_reset_mid_access;
    drive(32'h500, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    ready = 1'b0;
    tick;
    tick;
    n_checks++;
    if (req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %b want 1", req); end
    rst = 1'b1;
    clear_inputs;
    tick;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({req, stall, done, berr, mis, be, maddr, rdata_out} !== 73'b0) begin
      n_fail++; $display("FAIL rst_mid: got req=%b stall=%b done=%b berr=%b mis=%b be=%b addr=%h rd=%h want zeros",
                         req, stall, done, berr, mis, be, maddr, rdata_out);
    end
    tick;
    n_checks++;
    if (req !== 1'b0) begin n_fail++; $display("FAIL rst_no_relaunch: got req=%b want 0", req); end
    zero_wait_load("post_rst", 32'h104, 2'b10, 1'b0, 32'h11223344, 32'h11223344);
  endtask

  initial begin
    clear_inputs;
    rst = 1'b1;
    test_reset;
    test_zero_wait_load;
    test_byte_half_loads;
    test_stores;
    test_wait_states;
    test_misaligned;
    test_timeout;
    test_reset_mid_access;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU.
- Consumes the ALU result as the effective address and the rt register value as store data.
- Drives a ready/req handshake to the data memory, handles byte/halfword/word lane steering and load extension, and stalls the core until each access completes.
- Little-endian byte order. Data path fixed at 32 bits.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in ACCESS without i_mem_ready before aborting; 0 disables the timeout.

Ports:
- i_clk  input  1  single clock, all state updates on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_ALUresult  input  32  effective address from ALU
- i_write_data  input  32  store data (rt)
- i_MemRead  input  1  load request
- i_MemWrite  input  1  store request; wins if both set
- i_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
- i_unsigned  input  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend
- o_stall  output  1  hold PC/pipeline
- o_read_data  output  32  extended load result
- o_done  output  1  one-cycle pulse, access completed
- o_misaligned  output  1  one-cycle pulse, alignment fault
- o_bus_error  output  1  one-cycle pulse, timeout abort
- o_mem_req  output  1  memory request
- o_mem_we  output  1  1 = write
- o_mem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- o_mem_wdata  output  32  lane-replicated store data
- o_mem_be  output  4  byte enables
- i_mem_ready  input  1  memory accepts/completes the access this cycle
- i_mem_rdata  input  32  read word, valid when i_mem_ready=1

Behaviour:
- Reset values: state IDLE, timeout counter 0, all outputs 0.
- States: IDLE, ACCESS, DONE.
- IDLE, access present (i_MemRead|i_MemWrite):
  - If misaligned (half with addr[0]=1; word with addr[1:0]!=0): pulse o_misaligned next cycle, stay in IDLE, no request, o_stall=0.
  - Otherwise: latch address, size, unsigned, we, wdata and be; go to ACCESS.
  - o_stall=1 combinationally in that same cycle.
- ACCESS:
  - o_mem_req=1 and o_stall=1.
  - Request fields come from latches and stay stable until handshake.
  - On i_mem_ready=1: capture the load result into o_read_data (loads only; stores leave it unchanged), go to DONE.
  - Otherwise increment the counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES: drop req, pulse o_bus_error, go to DONE without updating o_read_data.
- DONE:
  - o_done=1 (normal completion only), o_stall=0, o_mem_req=0.
  - Core advances at this edge. Always returns to IDLE and does not re-launch the access held on the inputs that cycle.
- Store lane steering:
  - byte: wdata={4{rt[7:0]}}, be=4'b0001<<addr[1:0]
  - half: wdata={2{rt[15:0]}}, be=addr[1]?4'b1100:4'b0011
  - word: wdata=rt, be=4'b1111
- Loads: o_mem_be=4'b1111, o_mem_we=0.
- Load extraction:
  - byte = rdata[8*addr[1:0]+:8]
  - half = rdata[16*addr[1]+:16]
  - Sign- or zero-extend per latched i_unsigned.
- o_read_data holds its value until the next successful load.
- Exactly one access per instruction. Latency is 2 stall cycles with zero-wait memory (IDLE-detect and ACCESS), done in the third cycle.
- i_rst mid-ACCESS: next cycle req=0, state IDLE, pending access discarded.
- i_mem_ready outside ACCESS is ignored.

Test Plan:
- Zero-wait word load: addr 0x100, ready=1 on first ACCESS cycle, rdata 0xDEADBEEF -> req for 1 cycle, mem_addr=0x100, o_done pulse, o_read_data=0xDEADBEEF, stall high exactly 2 cycles.
- Signed/unsigned byte loads: addr 0x103, rdata 0x80AABBCC -> lb gives 0xFFFFFF80; lbu gives 0x00000080. Half at 0x102 signed gives 0xFFFF80AA.
- Byte store addr 0x201, rt=0x12345678 -> mem_we=1, be=4'b0010, wdata=0x78787878, mem_addr=0x200. Half store at 0x202 -> be=4'b1100, wdata=0x56785678.
- Wait states: ready held low 3 cycles then high -> req and all request fields stable for 4 cycles, single o_done, no bus_error.
- Faults: lw at 0x101 -> o_misaligned pulse, no req, stall 0. TIMEOUT_CYCLES=4 with ready never asserted -> req high 4 cycles, o_bus_error pulse, o_read_data unchanged, return to IDLE.
- Reset during ACCESS (ready low) -> next cycle req=0, stall=0, outputs 0. A subsequent load completes normally.
